// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding
// and the default operand width.
package mult_pkg;

   localparam int MULT_WIDTH = 4;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_ADD   = 2'd1;
   localparam state_t S_SHIFT = 2'd2;
   localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/ripple_adder_nbit.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Ports: a, b operands; cin carry in; sum result; cout carry out.
module ripple_adder_nbit #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-add multiplier with start/busy/done handshake.
// Ports: clk, rst (sync, high); start, A, B in; P product, busy, done out.
module shift_add_mult_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] P,
   output logic               busy,
   output logic               done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic             cy;
   logic [WIDTH-1:0] sum;
   logic             cout;

   ripple_adder_nbit #(.WIDTH(WIDTH)) u_add (
      .a    (acc),
      .b    (mcand),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (start) nxt = S_ADD;
         S_ADD:   nxt = S_SHIFT;
         S_SHIFT: nxt = (count == LAST) ? S_DONE : S_ADD;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // {cy,acc,mq} forms one shift register; the adder carry survives the
   // shift by entering acc[WIDTH-1] through cy.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         mcand <= '0;
         acc   <= '0;
         mq    <= '0;
         cy    <= 1'b0;
         P     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  mcand <= A;
                  mq    <= B;
                  acc   <= '0;
                  cy    <= 1'b0;
                  count <= '0;
               end
            end
            S_ADD: begin
               if (mq[0]) begin
                  acc <= sum;
                  cy  <= cout;
               end
            end
            S_SHIFT: begin
               cy  <= 1'b0;
               acc <= {cy, acc[WIDTH-1:1]};
               mq  <= {acc[0], mq[WIDTH-1:1]};
               if (count == LAST)
                  P <= {cy, acc, mq[WIDTH-1:1]};
               else
                  count <= count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl at WIDTH=4.
// Reference model: product is A*B, done arrives 2*WIDTH edges after start.
module tb_shift_add_mult_ctrl;

   localparam int W   = 4;
   localparam int LAT = 2 * W;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [2*W-1:0] P;
   logic           busy;
   logic           done;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic prev_done = 1'b0;
   int   last_exp = 0;

   always #5 clk = ~clk;

   shift_add_mult_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   task automatic tick();
      @(negedge clk);
      n_checks++;
      if (done === 1'b1 && prev_done === 1'b1) begin
         n_fail++;
         $display("FAIL done_twice: done=%b prev=%b, required not both 1",
                  done, prev_done);
      end
      n_checks++;
      if (done === 1'b1 && busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_in_done: busy=%b, required 1", busy);
      end
      prev_done = done;
   endtask

   task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] b);
      A     = a;
      B     = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 4 * LAT) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      A     = 4'd5;
      B     = 4'd3;
      tick();
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || P !== '0) begin
         n_fail++;
         $display("FAIL reset: busy=%b done=%b P=%h, required 0 0 00",
                  busy, done, P);
      end
      rst   = 1'b0;
      start = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input string name);
      int lat;
      int exp;
      exp = int'(a) * int'(b);
      start_job(a, b);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_busy: busy=%b, required 1", name, busy);
      end
      wait_done(lat);
      n_checks++;
      if (lat != LAT) begin
         n_fail++;
         $display("FAIL %s_lat: latency=%0d, required %0d", name, lat, LAT);
      end
      n_checks++;
      if (P !== (2*W)'(exp)) begin
         n_fail++;
         $display("FAIL %s_P: P=%0d, required %0d", name, P, exp);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || P !== (2*W)'(exp)) begin
         n_fail++;
         $display("FAIL %s_hold: busy=%b done=%b P=%0d, required 0 0 %0d",
                  name, busy, done, P, exp);
      end
      last_exp = exp;
   endtask

   task automatic test_basic();
      test_one(4'd13, 4'd11, "basic");
   endtask

   task automatic test_max();
      test_one(4'd15, 4'd15, "max");
   endtask

   task automatic test_zero();
      test_one(4'd0, 4'd9, "zero_a");
      test_one(4'd9, 4'd0, "zero_b");
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           exp;
      int           ndone;
      int           done_at;
      logic [2*W-1:0] pcap;
      a       = W'($urandom_range(1, 15));
      b       = W'($urandom_range(1, 15));
      exp     = int'(a) * int'(b);
      ndone   = 0;
      done_at = -1;
      pcap    = '0;
      start_job(a, b);
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (done === 1'b1) begin
            ndone++;
            done_at = c;
            pcap    = P;
         end
         start = (c == 3 || c == 8);
         if (start) begin
            A = ~a;
            B = W'($urandom);
         end
      end
      start = 1'b0;
      n_checks++;
      if (ndone != 1 || done_at != LAT) begin
         n_fail++;
         $display("FAIL ignore_done: pulses=%0d at=%0d, required 1 at %0d",
                  ndone, done_at, LAT);
      end
      n_checks++;
      if (pcap !== (2*W)'(exp) || P !== (2*W)'(exp)) begin
         n_fail++;
         $display("FAIL ignore_P: P=%0d/%0d, required %0d", pcap, P, exp);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_idle: busy=%b, required 0", busy);
      end
      last_exp = exp;
   endtask

   task automatic test_mid_reset();
      start_job(W'($urandom_range(1, 15)), W'($urandom_range(1, 15)));
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || P !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: busy=%b done=%b P=%0d, required 0 0 0",
                  busy, done, P);
      end
      rst = 1'b0;
      test_one(4'd6, 4'd7, "after_reset");
   endtask

   task automatic test_back_to_back();
      int t;
      int nd;
      int d_last;
      int lat;
      nd     = 0;
      d_last = -100;
      A      = 4'd3;
      B      = 4'd5;
      start  = 1'b1;
      for (t = 1; t <= 35; t++) begin
         tick();
         if (t == d_last + 1) begin
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_gap: t=%0d busy=%b, required 0", t, busy);
            end
         end
         if (t == d_last + 2) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_restart: t=%0d busy=%b, required 1", t, busy);
            end
         end
         if (done === 1'b1) begin
            n_checks++;
            if (t != LAT + 1 + nd * (LAT + 2) || P !== 8'd15) begin
               n_fail++;
               $display("FAIL b2b_done: t=%0d P=%0d, required t=%0d P=15",
                        t, P, LAT + 1 + nd * (LAT + 2));
            end
            nd++;
            d_last = t;
         end
      end
      n_checks++;
      if (nd != 3) begin
         n_fail++;
         $display("FAIL b2b_count: pulses=%0d, required 3", nd);
      end
      start = 1'b0;
      wait_done(lat);
      n_checks++;
      if (done !== 1'b1 || P !== 8'd15) begin
         n_fail++;
         $display("FAIL b2b_drain: done=%b P=%0d, required 1 15", done, P);
      end
      tick();
      last_exp = 15;
   endtask

   task automatic test_exhaustive();
      int idx[256];
      int tmp;
      int lat;
      int exp;
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int i = 0; i < 256; i++) idx[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j;
         j      = int'($urandom_range(0, i));
         tmp    = idx[i];
         idx[i] = idx[j];
         idx[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) tick();
         a   = W'(idx[i] >> W);
         b   = W'(idx[i]);
         exp = int'(a) * int'(b);
         start_job(a, b);
         n_checks++;
         if (P !== (2*W)'(last_exp)) begin
            n_fail++;
            $display("FAIL exh_hold: P=%0d, required %0d", P, last_exp);
         end
         lat = 0;
         while (done !== 1'b1 && lat < 4 * LAT) begin
            A     = W'($urandom);
            B     = W'($urandom);
            start = 1'($urandom);
            tick();
            lat++;
         end
         start = 1'b0;
         n_checks++;
         if (lat != LAT || P !== (2*W)'(exp)) begin
            n_fail++;
            $display("FAIL exh %0d*%0d: P=%0d lat=%0d, required %0d lat=%0d",
                     a, b, P, lat, exp, LAT);
         end
         tick();
         last_exp = exp;
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      test_reset();
      test_basic();
      test_max();
      test_zero();
      test_ignore_start();
      test_mid_reset();
      test_back_to_back();
      test_exhaustive();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
